// File: rtl/seq_divider.sv
// seq_divider: sequential restoring unsigned divider for the ALU divide path.
// Resolves one quotient bit per clock and raises a one-cycle done pulse when the
// results are loaded.
//
// Ports
//   clk        system clock, rising edge
//   res        asynchronous active-low reset
//   divisible  dividend from the operand-ordering stage
//   divider    divisor from the operand-ordering stage
//   ready      operand pair valid (may be held high for many cycles)
//   busy       high while iterating
//   quotient   result quotient, held until the next completion
//   remainder  result remainder, held until the next completion
//   dz         divide-by-zero flag of the last completed operation
//   done       one-cycle pulse, results valid in that cycle
//
// state | meaning
// IDLE  | waiting for a new operand pair (start evaluated here only)
// RUN   | one restoring iteration per clock
// DONE  | results loaded, done pulse high for this one cycle
module seq_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             res,
    input  logic [WIDTH-1:0] divisible,
    input  logic [WIDTH-1:0] divider,
    input  logic             ready,
    output logic             busy,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dz,
    output logic             done
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    // d_r shifts out dividend bits at the top and collects quotient bits at
    // the bottom, so after WIDTH iterations it holds the quotient.
    logic [WIDTH-1:0]   d_r;
    logic [WIDTH-1:0]   v_r;
    // The partial remainder is always < divisor after an iteration, so it is
    // stored in WIDTH bits; only the shifted value needs the extra bit.
    logic [WIDTH-1:0]   p_r;
    logic               ready_q;
    logic [2*WIDTH-1:0] last_pair;

    logic [WIDTH:0]     p_shift;
    logic               p_ge;
    logic [WIDTH-1:0]   p_next;
    logic [WIDTH-1:0]   d_next;
    logic               start;

    always_comb begin
        p_shift = {p_r, d_r[WIDTH-1]};
        p_ge    = (p_shift >= {1'b0, v_r});
        p_next  = p_ge ? WIDTH'(p_shift - {1'b0, v_r}) : p_shift[WIDTH-1:0];
        d_next  = {d_r[WIDTH-2:0], p_ge};
        // A held-high ready with an unchanged pair must not retrigger.
        start   = (state == IDLE) && ready &&
                  (!ready_q || ({divisible, divider} != last_pair));
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state     <= IDLE;
            cnt       <= '0;
            d_r       <= '0;
            v_r       <= '0;
            p_r       <= '0;
            ready_q   <= 1'b0;
            last_pair <= '0;
            busy      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            dz        <= 1'b0;
            done      <= 1'b0;
        end else begin
            ready_q <= ready;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        last_pair <= {divisible, divider};
                        d_r       <= divisible;
                        v_r       <= divider;
                        cnt       <= '0;
                        p_r       <= '0;
                        if (divider == '0) begin
                            quotient  <= '1;
                            remainder <= divisible;
                            dz        <= 1'b1;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            busy  <= 1'b1;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    d_r <= d_next;
                    p_r <= p_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        quotient  <= d_next;
                        remainder <= p_next;
                        dz        <= 1'b0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: self-checking bench for seq_divider (WIDTH = 16) using a
// plain-arithmetic reference model (/, %) and randomized operand pairs.
module tb_seq_divider;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         res = 1'b0;
    logic [W-1:0] divisible = '0;
    logic [W-1:0] divider = '0;
    logic         ready = 1'b0;
    logic         busy;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         dz;
    logic         done;

    int n_pass  = 0;
    int n_total = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .res       (res),
        .divisible (divisible),
        .divider   (divider),
        .ready     (ready),
        .busy      (busy),
        .quotient  (quotient),
        .remainder (remainder),
        .dz        (dz),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r,
                                    output logic z);
        if (b == 0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else begin
            q = a / b;
            r = a % b;
            z = 1'b0;
        end
    endfunction

    // Drops ready for one edge, presents a pair with ready high, then waits
    // (bounded) for the done pulse. Ready is left high afterwards.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output int cycles, output int busy_cycles, output bit got,
                          output logic [W-1:0] q_o, output logic [W-1:0] r_o,
                          output logic dz_o);
        @(negedge clk);
        ready = 1'b0;
        @(negedge clk);
        divisible = a;
        divider   = b;
        ready     = 1'b1;
        cycles = 0;
        busy_cycles = 0;
        got = 1'b0;
        q_o = 'x;
        r_o = 'x;
        dz_o = 1'bx;
        while (!got && cycles < 40) begin
            @(negedge clk);
            cycles++;
            if (busy) busy_cycles++;
            if (done) begin
                got  = 1'b1;
                q_o  = quotient;
                r_o  = remainder;
                dz_o = dz;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_total++; if ({busy, done, dz} !== 3'b000) $display("FAIL reset_flags got=%b exp=000", {busy, done, dz}); else n_pass++;
        n_total++; if (quotient !== 16'd0) $display("FAIL reset_quot got=%0d exp=0", quotient); else n_pass++;
        n_total++; if (remainder !== 16'd0) $display("FAIL reset_rem got=%0d exp=0", remainder); else n_pass++;
        res = 1'b1;
        repeat (3) @(negedge clk);
        n_total++; if ({busy, done} !== 2'b00) $display("FAIL idle_after_reset got=%b exp=00", {busy, done}); else n_pass++;
    endtask

    task automatic test_basic();
        int cyc, bcyc; bit got; logic [W-1:0] q, r; logic z;
        run_op(16'd100, 16'd7, cyc, bcyc, got, q, r, z);
        n_total++; if (!got) $display("FAIL t1_done got=no_done exp=done"); else n_pass++;
        n_total++; if (cyc !== 17) $display("FAIL t1_latency got=%0d exp=17", cyc); else n_pass++;
        n_total++; if (bcyc !== 16) $display("FAIL t1_busy_cycles got=%0d exp=16", bcyc); else n_pass++;
        n_total++; if (q !== 16'd14) $display("FAIL t1_quot got=%0d exp=14", q); else n_pass++;
        n_total++; if (r !== 16'd2) $display("FAIL t1_rem got=%0d exp=2", r); else n_pass++;
        n_total++; if (z !== 1'b0) $display("FAIL t1_dz got=%b exp=0", z); else n_pass++;
        @(negedge clk);
        n_total++; if (done !== 1'b0) $display("FAIL t1_done_width got=%b exp=0", done); else n_pass++;
    endtask

    task automatic test_edges();
        int cyc, bcyc; bit got; logic [W-1:0] q, r; logic z;
        run_op(16'hFFFF, 16'd1, cyc, bcyc, got, q, r, z);
        n_total++; if (!got || q !== 16'hFFFF || r !== 16'd0) $display("FAIL t2_div1 got=%0b/%h/%h exp=1/ffff/0000", got, q, r); else n_pass++;
        run_op(16'hFFFF, 16'hFFFF, cyc, bcyc, got, q, r, z);
        n_total++; if (!got || q !== 16'd1 || r !== 16'd0) $display("FAIL t2_divmax got=%0b/%h/%h exp=1/0001/0000", got, q, r); else n_pass++;
        run_op(16'hFFFE, 16'hFFFF, cyc, bcyc, got, q, r, z);
        n_total++; if (!got || q !== 16'd0 || r !== 16'hFFFE) $display("FAIL t2_small got=%0b/%h/%h exp=1/0000/fffe", got, q, r); else n_pass++;
    endtask

    task automatic test_zero();
        int cyc, bcyc; bit got; logic [W-1:0] q, r; logic z;
        run_op(16'd5, 16'd0, cyc, bcyc, got, q, r, z);
        n_total++; if (!got || cyc !== 1) $display("FAIL t3_latency got=%0d exp=1", cyc); else n_pass++;
        n_total++; if (bcyc !== 0) $display("FAIL t3_busy got=%0d exp=0", bcyc); else n_pass++;
        n_total++; if (q !== 16'hFFFF || r !== 16'd5) $display("FAIL t3_result got=%h/%h exp=ffff/0005", q, r); else n_pass++;
        n_total++; if (z !== 1'b1) $display("FAIL t3_dz got=%b exp=1", z); else n_pass++;
    endtask

    task automatic test_random();
        int cyc, bcyc; bit got; logic [W-1:0] q, r, eq, er, a, b; logic z, ez;
        for (int i = 0; i < 40; i++) begin
            a = W'($urandom_range(0, 65535));
            case ($urandom_range(0, 3))
                0:       b = W'($urandom_range(1, 15));
                1:       b = W'($urandom_range(0, 65535));
                2:       b = ($urandom_range(0, 3) == 0) ? 16'd0 : W'($urandom_range(1, 255));
                default: b = (a == 0) ? 16'd1 : W'($urandom_range(1, int'(a)));
            endcase
            ref_div(a, b, eq, er, ez);
            run_op(a, b, cyc, bcyc, got, q, r, z);
            n_total++;
            if (!got || q !== eq || r !== er || z !== ez || cyc !== ((b == 0) ? 1 : 17))
                $display("FAIL rand_%0d %0d/%0d got=%h/%h/%b cyc=%0d exp=%h/%h/%b cyc=%0d",
                         i, a, b, q, r, z, cyc, eq, er, ez, (b == 0) ? 1 : 17);
            else n_pass++;
        end
    endtask

    task automatic test_hold();
        int pulses; bit got;
        @(negedge clk); ready = 1'b0;
        @(negedge clk); divisible = 16'd100; divider = 16'd7; ready = 1'b1;
        pulses = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        n_total++; if (pulses !== 1) $display("FAIL t4_hold_pulses got=%0d exp=1", pulses); else n_pass++;
        n_total++; if (quotient !== 16'd14 || remainder !== 16'd2) $display("FAIL t4_first got=%0d/%0d exp=14/2", quotient, remainder); else n_pass++;
        divisible = 16'd200; divider = 16'd9;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        n_total++; if (!got || quotient !== 16'd22 || remainder !== 16'd2) $display("FAIL t4_second got=%0b/%0d/%0d exp=1/22/2", got, quotient, remainder); else n_pass++;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        n_total++; if (pulses !== 0) $display("FAIL t4_no_retrigger got=%0d exp=0", pulses); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int cyc, bcyc, pulses; bit got; logic [W-1:0] q, r; logic z;
        @(negedge clk); ready = 1'b0;
        @(negedge clk); divisible = 16'd1000; divider = 16'd3; ready = 1'b1;
        repeat (8) @(negedge clk);
        n_total++; if (busy !== 1'b1) $display("FAIL t5_busy_before got=%b exp=1", busy); else n_pass++;
        ready = 1'b0;
        res = 1'b0;
        #1;
        n_total++; if ({busy, done, dz} !== 3'b000 || quotient !== 16'd0 || remainder !== 16'd0)
            $display("FAIL t5_async_clear got=%b/%0d/%0d exp=000/0/0", {busy, done, dz}, quotient, remainder);
        else n_pass++;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        res = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        n_total++; if (pulses !== 0) $display("FAIL t5_no_done got=%0d exp=0", pulses); else n_pass++;
        run_op(16'd1000, 16'd3, cyc, bcyc, got, q, r, z);
        n_total++; if (!got || q !== 16'd333 || r !== 16'd1 || cyc !== 17) $display("FAIL t5_rerun got=%0b/%0d/%0d cyc=%0d exp=1/333/1 cyc=17", got, q, r, cyc); else n_pass++;
    endtask

    task automatic test_change_during_run();
        bit got;
        @(negedge clk); ready = 1'b0;
        @(negedge clk); divisible = 16'd100; divider = 16'd7; ready = 1'b1;
        repeat (4) @(negedge clk);
        divisible = 16'd50; divider = 16'd5;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        n_total++; if (!got || quotient !== 16'd14 || remainder !== 16'd2) $display("FAIL t6_first got=%0b/%0d/%0d exp=1/14/2", got, quotient, remainder); else n_pass++;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (busy) got = 1'b1;
        end
        n_total++; if (!got || quotient !== 16'd14 || remainder !== 16'd2) $display("FAIL t6_hold_during_run got=%0b/%0d/%0d exp=1/14/2", got, quotient, remainder); else n_pass++;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        n_total++; if (!got || quotient !== 16'd10 || remainder !== 16'd0) $display("FAIL t6_second got=%0b/%0d/%0d exp=1/10/0", got, quotient, remainder); else n_pass++;
        ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_edges();
        test_zero();
        test_hold();
        test_reset_mid();
        test_change_during_run();
        test_random();
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
